// File: rtl/alu_exec_unit_if.sv
// Request/response bundle for alu_exec_unit: operation request in, result out.
// The master side issues operations and consumes results; the slave side is the unit.
interface alu_exec_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic        overflow;

    modport master (
        output in_valid, alu_ctrl, op_a, op_b, shamt, out_ready,
        input  in_ready, out_valid, result, zero, illegal, overflow
    );

    modport slave (
        input  in_valid, alu_ctrl, op_a, op_b, shamt, out_ready,
        output in_ready, out_valid, result, zero, illegal, overflow
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Single-issue ALU execution unit with a serial one-bit-per-cycle shifter.
// Define ALU_OVERFLOW_EN to build the signed ADD/SUB overflow flag; otherwise overflow is tied to 0.
module alu_exec_unit (
    input  logic           clk,
    input  logic           reset,
    alu_exec_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t      state, state_next;
    logic [31:0] result_q, result_next;
    logic        illegal_q, illegal_next;
    logic [4:0]  cnt_q, cnt_next;
    logic        dir_q, dir_next;
    logic [31:0] sum;
    logic [31:0] diff;

`ifdef ALU_OVERFLOW_EN
    logic        ovf_q, ovf_next;
`endif

    assign sum  = bus.op_a + bus.op_b;
    assign diff = bus.op_a - bus.op_b;

    // The acceptance edge already performs the first shift step, so a shift by k
    // spends k-1 edges in SHIFT and completes with the same latency k as other ops.
    always_comb begin
        state_next   = state;
        result_next  = result_q;
        illegal_next = illegal_q;
        cnt_next     = cnt_q;
        dir_next     = dir_q;
`ifdef ALU_OVERFLOW_EN
        ovf_next     = ovf_q;
`endif
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_next   = DONE;
                    illegal_next = 1'b0;
`ifdef ALU_OVERFLOW_EN
                    ovf_next     = 1'b0;
`endif
                    case (bus.alu_ctrl)
                        4'b0000: result_next = bus.op_a & bus.op_b;
                        4'b0001: result_next = bus.op_a | bus.op_b;
                        4'b0010: begin
                            result_next = sum;
`ifdef ALU_OVERFLOW_EN
                            ovf_next = (bus.op_a[31] == bus.op_b[31]) && (sum[31] != bus.op_a[31]);
`endif
                        end
                        4'b0011: result_next = bus.op_a ^ bus.op_b;
                        4'b0110: begin
                            result_next = diff;
`ifdef ALU_OVERFLOW_EN
                            ovf_next = (bus.op_a[31] != bus.op_b[31]) && (diff[31] != bus.op_a[31]);
`endif
                        end
                        4'b0111: result_next = {31'd0, $signed(bus.op_a) < $signed(bus.op_b)};
                        4'b1000, 4'b1001: begin
                            dir_next = bus.alu_ctrl[0];
                            if (bus.shamt == 5'd0) begin
                                result_next = bus.op_b;
                            end else begin
                                result_next = bus.alu_ctrl[0] ? (bus.op_b >> 1) : (bus.op_b << 1);
                                cnt_next    = bus.shamt - 5'd1;
                                if (bus.shamt != 5'd1)
                                    state_next = SHIFT;
                            end
                        end
                        4'b1100: result_next = ~(bus.op_a | bus.op_b);
                        default: begin
                            result_next  = 32'd0;
                            illegal_next = 1'b1;
                        end
                    endcase
                end
            end
            SHIFT: begin
                result_next = dir_q ? (result_q >> 1) : (result_q << 1);
                cnt_next    = cnt_q - 5'd1;
                if (cnt_q == 5'd1)
                    state_next = DONE;
            end
            DONE: begin
                if (bus.out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            result_q  <= 32'd0;
            illegal_q <= 1'b0;
            cnt_q     <= 5'd0;
            dir_q     <= 1'b0;
`ifdef ALU_OVERFLOW_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            result_q  <= result_next;
            illegal_q <= illegal_next;
            cnt_q     <= cnt_next;
            dir_q     <= dir_next;
`ifdef ALU_OVERFLOW_EN
            ovf_q     <= ovf_next;
`endif
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.illegal   = illegal_q;
    // zero is qualified by DONE so it reads 0 out of reset even though result is 0
    assign bus.zero      = (state == DONE) && (result_q == 32'd0);
`ifdef ALU_OVERFLOW_EN
    assign bus.overflow  = ovf_q;
`else
    assign bus.overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases, a reset abort, then random traffic.
// Expected values come from an arithmetic reference model of the operation table.
module tb_alu_exec_unit;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    alu_exec_unit_if bus ();

    alu_exec_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference model: operation table evaluated with plain integer arithmetic
    task automatic refModel(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] sh, output logic [31:0] res, output logic ill,
                            output logic ovf, output int lat);
        longint sa, sb, wide;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        wide = 0;
        ill  = 1'b0;
        lat  = 1;
        case (ctrl)
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b0010: begin wide = sa + sb; res = a + b; end
            4'b0011: res = a ^ b;
            4'b0110: begin wide = sa - sb; res = a - b; end
            4'b0111: res = (sa < sb) ? 32'd1 : 32'd0;
            4'b1000: begin res = b << sh; lat = (sh == 0) ? 1 : int'(sh); end
            4'b1001: begin res = b >> sh; lat = (sh == 0) ? 1 : int'(sh); end
            4'b1100: res = ~(a | b);
            default: begin res = 32'd0; ill = 1'b1; end
        endcase
`ifdef ALU_OVERFLOW_EN
        ovf = (ctrl == 4'b0010 || ctrl == 4'b0110) && (wide > 64'sd2147483647 || wide < -64'sd2147483648);
`else
        ovf = 1'b0;
`endif
    endtask

    task automatic scramble();
        bus.in_valid = 1'($urandom);
        bus.alu_ctrl = 4'($urandom);
        bus.op_a     = $urandom;
        bus.op_b     = $urandom;
        bus.shamt    = 5'($urandom);
    endtask

    // Issue one operation, measure latency, hold the result for 'hold' cycles, then drain it
    task automatic applyStimulus(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh, input int hold);
        logic [31:0] exp_res;
        logic        exp_ill;
        logic        exp_ovf;
        int          exp_lat;
        int          cycles;
        refModel(ctrl, a, b, sh, exp_res, exp_ill, exp_ovf, exp_lat);
        @(negedge clk);
        checkOutput("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.alu_ctrl = ctrl;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.shamt    = sh;
        @(negedge clk);
        cycles = 1;
        while (!bus.out_valid && cycles < 64) begin
            scramble();
            @(negedge clk);
            cycles++;
        end
        if (!bus.out_valid) begin
            checkOutput("timeout", 0, 1);
        end else begin
            checkOutput("latency", cycles, exp_lat);
            checkOutput("result", bus.result, exp_res);
            checkOutput("zero", bus.zero, exp_res == 32'd0);
            checkOutput("illegal", bus.illegal, exp_ill);
            checkOutput("overflow", bus.overflow, exp_ovf);
            checkOutput("in_ready_busy", bus.in_ready, 0);
            for (int i = 0; i < hold; i++) begin
                scramble();
                @(negedge clk);
                checkOutput("hold_valid", bus.out_valid, 1);
                checkOutput("hold_result", bus.result, exp_res);
                checkOutput("hold_zero", bus.zero, exp_res == 32'd0);
                checkOutput("hold_in_ready", bus.in_ready, 0);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("drain_valid", bus.out_valid, 0);
        checkOutput("drain_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int seen_valid;
        total         = 0;
        bad           = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.alu_ctrl  = 4'd0;
        bus.op_a      = 32'd0;
        bus.op_b      = 32'd0;
        bus.shamt     = 5'd0;
        bus.out_ready = 1'b0;
        #2;
        checkOutput("rst_in_ready", bus.in_ready, 1);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_result", bus.result, 0);
        checkOutput("rst_zero", bus.zero, 0);
        checkOutput("rst_illegal", bus.illegal, 0);
        checkOutput("rst_overflow", bus.overflow, 0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(4'b0010, 32'h00000005, 32'h00000003, 5'd0, 0);
        applyStimulus(4'b0110, 32'h00000007, 32'h00000007, 5'd0, 3);
        applyStimulus(4'b1001, 32'h12345678, 32'h80000000, 5'd31, 0);
        applyStimulus(4'b1001, 32'h12345678, 32'h80000000, 5'd0, 0);
        applyStimulus(4'b0111, 32'hFFFFFFFF, 32'h00000001, 5'd0, 0);
        applyStimulus(4'b1111, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'd0, 1);
        applyStimulus(4'b0010, 32'h7FFFFFFF, 32'h00000001, 5'd0, 0);
        applyStimulus(4'b0110, 32'h80000000, 32'h00000001, 5'd0, 0);
        applyStimulus(4'b1000, 32'h0, 32'h00000001, 5'd1, 0);

        // Reset pulse in the middle of a long shift
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.alu_ctrl = 4'b1000;
        bus.op_b     = 32'h0000ABCD;
        bus.shamt    = 5'd10;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midrst_in_ready", bus.in_ready, 1);
        checkOutput("midrst_out_valid", bus.out_valid, 0);
        checkOutput("midrst_result", bus.result, 0);
        @(negedge clk);
        checkOutput("midrst_in_ready_held", bus.in_ready, 1);
        reset = 1'b0;
        seen_valid = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) seen_valid++;
        end
        checkOutput("midrst_no_valid", seen_valid, 0);
        applyStimulus(4'b0010, 32'h00000010, 32'h00000020, 5'd0, 0);

        for (int n = 0; n < 40; n++) begin
            applyStimulus(4'($urandom), $urandom, $urandom, 5'($urandom), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 Port clk SHALL be an input, 1 bit wide, and is the system clock; all state SHALL update on its rising edge.
REQ-003 Port reset SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-004 Port in_valid SHALL be an input, 1 bit wide: the operation request is valid.
REQ-005 Port in_ready SHALL be an output, 1 bit wide: the unit can accept a request.
REQ-006 Port alu_ctrl SHALL be an input, 4 bits wide: the operation code produced by the ALU control decoder.
REQ-007 Ports op_a and op_b SHALL be inputs, 32 bits wide each: op_a is rs and op_b is rt.
REQ-008 Port shamt SHALL be an input, 5 bits wide: the shift amount for SLL and SRL.
REQ-009 Port out_valid SHALL be an output, 1 bit wide: result is valid.
REQ-010 Port out_ready SHALL be an input, 1 bit wide: the consumer accepts the result.
REQ-011 Port result SHALL be an output, 32 bits wide: the operation result.
REQ-012 Port zero SHALL be an output, 1 bit wide: asserted when result equals 0.
REQ-013 Port illegal SHALL be an output, 1 bit wide: the accepted alu_ctrl code is undefined.
REQ-014 Port overflow SHALL be an output, 1 bit wide: signed overflow, as defined in REQ-030.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, SHIFT and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; alu_ctrl, op_a, op_b and shamt SHALL be captured at that edge.
REQ-017 The decoding SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB (a-b), 0111 SLT (signed, result 1 or 0), 1000 SLL, 1001 SRL, 1100 NOR.
REQ-018 Arithmetic SHALL be 32-bit modulo 2^32, with carry discarded.
REQ-019 For non-shift ops, result SHALL be registered at the acceptance edge; the FSM SHALL go IDLE->DONE, and out_valid SHALL be 1 in the next cycle (latency 1).
REQ-020 For SLL or SRL with shamt=k>0, the FSM SHALL go IDLE->SHIFT and shift op_b by one bit per edge (zero fill), then enter DONE after k edges (latency k cycles).
REQ-021 For SLL or SRL with shamt=0, result SHALL equal op_b, via IDLE->DONE with latency 1.
REQ-022 Any code not listed in REQ-017, including 1111, SHALL give result=0 and illegal=1 with latency 1; for all defined codes illegal=0.
REQ-023 In DONE, result, zero, illegal and overflow SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 In DONE, on an edge where out_ready=1, the FSM SHALL go DONE->IDLE, and out_valid SHALL fall; in_ready SHALL rise in the following cycle, with no same-cycle bypass.
REQ-025 Input changes while in SHIFT or DONE SHALL be ignored.
REQ-026 zero SHALL be computed from the final result and SHALL be valid whenever out_valid=1.

Reset
REQ-027 When reset=1, the block SHALL immediately force: state IDLE; out_valid=0; result=0; zero=0; illegal=0; overflow=0; in_ready=1.
REQ-028 Reset asserted mid-SHIFT or in DONE SHALL abort the operation and drop the pending result; reset SHALL dominate any simultaneous handshake.
REQ-029 After reset deasserts, the first rising edge SHALL be able to accept a request.

Configuration
REQ-030 With macro ALU_OVERFLOW_EN defined, overflow SHALL equal 1 for ADD or SUB whose signed 32-bit result overflows, and 0 for all other ops.
REQ-031 With ALU_OVERFLOW_EN undefined, the overflow port SHALL remain present and be tied to 0, and no overflow logic SHALL be synthesized.

Verification
REQ-032 The bench SHALL cover: ADD op_a=0x00000005, op_b=0x00000003 -> after 1 cycle, out_valid=1, result=0x00000008, zero=0.
REQ-033 The bench SHALL cover: SUB 7-7 with out_ready held 0 for 3 cycles -> result=0, zero=1, held stable; in_ready=0 until the cycle after the out_ready handshake.
REQ-034 The bench SHALL cover: SRL op_b=0x80000000, shamt=31 -> out_valid after 31 cycles, result=0x00000001; shamt=0 -> result=0x80000000 after 1 cycle.
REQ-035 The bench SHALL cover: SLT op_a=0xFFFFFFFF, op_b=0x00000001 -> result=1; alu_ctrl=1111 -> result=0, illegal=1.
REQ-036 The bench SHALL cover: ADD 0x7FFFFFFF+1 -> result=0x80000000; overflow=1 with ALU_OVERFLOW_EN defined, and 0 without it.
REQ-037 The bench SHALL cover: SLL shamt=10 with reset pulsed at cycle 4 -> out_valid stays 0, in_ready=1 during reset, and the next ADD completes normally.
